// File: rtl/uart_rx_capture.sv
// -----------------------------------------------------------------------------
// uart_rx_capture
//   Receives asynchronous serial characters (8N1-style framing with optional
//   parity) from a single line and stores them in a show-ahead capture FIFO.
//
//   Parameters
//     CLKS_PER_BIT : clk cycles per serial bit (even, >= 4)
//     DATA_BITS    : character width (5..8)
//     PARITY_MODE  : 0 = none, 1 = odd, 2 = even
//     FIFO_DEPTH   : capture FIFO entries (power of 2, >= 2)
//
//   Ports
//     clk          : single clock, rising edge
//     rst          : asynchronous active-high reset
//     rx_i         : serial line, asynchronous to clk, idles high
//     rd_i         : pop the FIFO head
//     clear_i      : synchronously clears the three sticky error flags
//     rd_data_o    : FIFO head (valid while empty_o = 0, 0 when empty)
//     empty_o      : FIFO empty
//     full_o       : FIFO full
//     count_o      : number of stored entries
//     overflow_o   : sticky, a character was dropped on a full FIFO
//     frame_err_o  : sticky, a stop bit was sampled as 0
//     parity_err_o : sticky, a parity mismatch was seen
//
//   Build option
//     UART_RX_CAPTURE_GLITCH_FILTER_EN : when defined, a 3-sample majority
//     filter follows the synchronizer (one extra cycle of latency, rejects
//     single-cycle glitches).
// -----------------------------------------------------------------------------
module uart_rx_capture #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  input  logic                          rd_i,
  input  logic                          clear_i,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Line conditioning: 2-flop synchronizer, optional majority filter.
  // Flops preset to 1 so reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       line;
  logic       line_prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rx_i};
  end

`ifdef UART_RX_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] filt_hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) filt_hist_q <= 2'b11;
    else     filt_hist_q <= {filt_hist_q[0], sync_q[1]};
  end

  // Majority of the current and two previous samples: a lone flipped sample
  // is outvoted, a real transition appears one cycle later.
  assign line = (sync_q[1] & filt_hist_q[0]) |
                (sync_q[1] & filt_hist_q[1]) |
                (filt_hist_q[0] & filt_hist_q[1]);
`else
  assign line = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_prev_q <= 1'b1;
    else     line_prev_q <= line;
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   push_q, push_d;
  logic                   set_frame, set_parity;
  logic                   tick;
  logic                   par_exp;

  assign tick    = (cnt_q == '0);
  assign par_exp = (PARITY_MODE == 1) ? ~^shift_q : ^shift_q;

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    push_d     = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (line_prev_q && !line) begin
          state_d = START;
          cnt_d   = HALF_M1;
          bit_d   = '0;
        end
      end

      START: begin
        if (tick) begin
          if (line) begin
            state_d = IDLE;               // false start
          end else begin
            state_d = DATA;
            cnt_d   = FULL_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DATA: begin
        if (tick) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};   // LSB arrives first
          cnt_d   = FULL_M1;
          if (bit_q == LAST_BIT) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      PARITY: begin
        if (tick) begin
          set_parity = (line != par_exp);
          cnt_d      = FULL_M1;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STOP: begin
        if (tick) begin
          if (line) begin
            push_d  = 1'b1;
            state_d = IDLE;
          end else begin
            set_frame = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (line) state_d = IDLE;         // line released after a break
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 empty_q, full_q;
  logic                 do_push, do_pop, ovf_set;

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign do_pop  = rd_i & ~empty_q;
  assign do_push = push_q & (~full_q | do_pop);
  assign ovf_set = push_q & full_q & ~do_pop;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;   // wraps at FIFO_DEPTH
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNTW'(FIFO_DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable
  // through rd_ptr_q while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign rd_data_o = empty_q ? '0 : mem[rd_ptr_q];
  assign empty_o   = empty_q;
  assign full_o    = full_q;
  assign count_o   = count_q;

  // ---------------------------------------------------------------------------
  // Sticky error flags; clear wins over a set in the same cycle.
  // ---------------------------------------------------------------------------
  logic overflow_q, frame_err_q, parity_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (clear_i) begin
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      overflow_q   <= overflow_q   | ovf_set;
      frame_err_q  <= frame_err_q  | set_frame;
      parity_err_q <= parity_err_q | set_parity;
    end
  end

  assign overflow_o   = overflow_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_capture
//   Directed bench for uart_rx_capture. One instance runs the default
//   configuration (no parity); a second instance runs even parity.
//   Stimulus changes on the falling clock edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_uart_rx_capture;

  localparam int CLKS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, ovf, ferr, perr;
  logic [4:0] count;

  logic       rx_p  = 1'b1;
  logic       rd_p  = 1'b0;
  logic       clr_p = 1'b0;
  logic [7:0] rd_data_p;
  logic       empty_p, full_p, ovf_p, ferr_p, perr_p;
  logic [4:0] count_p;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 0;

  always #5 clk = ~clk;

  uart_rx_capture u_dut (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .rd_i         (rd),
    .clear_i      (clr),
    .rd_data_o    (rd_data),
    .empty_o      (empty),
    .full_o       (full),
    .count_o      (count),
    .overflow_o   (ovf),
    .frame_err_o  (ferr),
    .parity_err_o (perr)
  );

  uart_rx_capture #(.PARITY_MODE(2)) u_dut_par (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx_p),
    .rd_i         (rd_p),
    .clear_i      (clr_p),
    .rd_data_o    (rd_data_p),
    .empty_o      (empty_p),
    .full_o       (full_p),
    .count_o      (count_p),
    .overflow_o   (ovf_p),
    .frame_err_o  (ferr_p),
    .parity_err_o (perr_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_p = v;
    else     rx   = v;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, par_bit);
    drive_bit(sel, stop);
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
    idle(4);
  endtask

  task automatic pop();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values, observed while reset is still asserted.
    idle(3);
    check("rst_empty",    empty,   1);
    check("rst_full",     full,    0);
    check("rst_count",    count,   0);
    check("rst_rd_data",  rd_data, 0);
    check("rst_flags",    {ovf, ferr, perr}, 0);
    rst = 1'b0;
    idle(4);

    // Single character 0x55; also measure frame-start-to-push delay.
    fork
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 1; k <= 170; k++) begin
          @(negedge clk);
          if (lat == 0 && count != 0) lat = k;
        end
      end
    join
    check("push_latency_window", (lat >= 150 && lat <= 165), 1);
    check("c55_empty",   empty,   0);
    check("c55_count",   count,   1);
    check("c55_data",    rd_data, 8'h55);
    pop();
    check("c55_pop_empty", empty, 1);
    check("c55_pop_count", count, 0);
    pop();                                   // read on empty is ignored
    check("rd_empty_count", count, 0);
    check("rd_empty_empty", empty, 1);

    // Fill, clear-priority, then overflow.
    for (int i = 0; i < 16; i++) send(8'(i));
    check("fill_full",  full,  1);
    check("fill_count", count, 16);
    check("fill_ovf",   ovf,   0);
    clr = 1'b1;
    send(8'h10);
    clr = 1'b0;
    check("clear_priority_ovf", ovf,   0);
    check("clear_priority_cnt", count, 16);
    send(8'h11);
    check("ovf_flag",  ovf,   1);
    check("ovf_full",  full,  1);
    check("ovf_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), rd_data, 32'(i));
      pop();
    end
    check("drain_empty", empty, 1);
    pulse_clear();
    check("ovf_cleared", ovf, 0);

    // 4-cycle glitch on the line: false start.
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_count", count, 0);
    check("glitch_flags", {ovf, ferr, perr}, 0);

    // Frame error with a held break, then recovery.
    send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("ferr_flag",  ferr,  1);
    check("ferr_count", count, 0);
    rx = 1'b1;
    idle(16);
    send(8'h3C);
    check("after_break_count", count,   1);
    check("after_break_data",  rd_data, 8'h3C);
    check("ferr_sticky",       ferr,    1);
    pulse_clear();
    check("ferr_cleared",       ferr,  0);
    check("clear_keeps_fifo",   count, 1);
    pop();

    // Even parity instance: 0x05 parity 0 good, 0x07 parity 0 bad.
    send_frame(1'b1, 8'h05, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("par_good_flag",  perr_p,  0);
    check("par_good_count", count_p, 1);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("par_bad_flag",   perr_p,  1);
    check("par_bad_count",  count_p, 2);
    rd_p = 1'b1;
    @(negedge clk);
    rd_p = 1'b0;
    check("par_bad_data",   rd_data_p, 8'h07);
    check("noparity_perr",  perr,      0);

    // Reset during data bit 3 of 0xFF.
    send(8'h12);
    check("pre_rst_count", count, 1);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    idle(8);
    rst = 1'b1;
    #1;
    check("midrst_count",   count,   0);
    check("midrst_empty",   empty,   1);
    check("midrst_full",    full,    0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_flags",   {ovf, ferr, perr, perr_p}, 0);
    idle(2);
    rst = 1'b0;
    idle(20);
    send(8'h81);
    check("post_rst_count", count,   1);
    check("post_rst_data",  rd_data, 8'h81);
    pop();

    // Full FIFO with a pop landing on the same edge as the push.
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
    check("sim_pre_full", full, 1);
    fork
      send_frame(1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    idle(4);
    check("sim_count", count, 16);
    check("sim_full",  full,  1);
    check("sim_ovf",   ovf,   0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sim_drain_%0d", i), rd_data, 32'(8'h21 + i));
      pop();
    end
    check("sim_drain_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
